// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the N-to-1 pipelined multiplexer.
//   MUX_MODE_DIRECT / MUX_MODE_RR : MODE input encodings
//   MUX_WIDTH_DEFAULT / MUX_N_DEFAULT : default channel width and channel count
package mux_pkg;

    localparam logic MUX_MODE_DIRECT = 1'b0;
    localparam logic MUX_MODE_RR     = 1'b1;

    localparam int MUX_WIDTH_DEFAULT = 32;
    localparam int MUX_N_DEFAULT     = 4;

endpackage

// File: rtl/mux_nto1_pipe_if.sv
// mux_nto1_pipe_if: channel and result bus of the N-to-1 pipelined multiplexer.
//   X, X_VALID, X_READY : flattened input channels (channel i at X[i*WIDTH +: WIDTH])
//   C, MODE             : channel select (direct mode) and mode (0 direct, 1 round-robin)
//   R, R_SEL, R_VALID, R_READY : registered result and its handshake
//   modport master : the side driving channels and consuming the result
//   modport slave  : the multiplexer
interface mux_nto1_pipe_if
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT,
    parameter int N     = MUX_N_DEFAULT,
    parameter int SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] X;
    logic [N-1:0]       X_VALID;
    logic [N-1:0]       X_READY;
    logic [SELW-1:0]    C;
    logic               MODE;
    logic [WIDTH-1:0]   R;
    logic [SELW-1:0]    R_SEL;
    logic               R_VALID;
    logic               R_READY;

    modport master (
        output X, X_VALID, C, MODE, R_READY,
        input  X_READY, R, R_SEL, R_VALID
    );

    modport slave (
        input  X, X_VALID, C, MODE, R_READY,
        output X_READY, R, R_SEL, R_VALID
    );
endinterface

// File: rtl/mux_nto1_pipe_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N requesters.
//   REQ     : request vector
//   PTR     : highest-priority index for this cycle
//   GNT     : one-hot grant
//   GNT_IDX : index of the granted requester
//   ANY     : at least one request present
// The search from PTR upward with wrap is done as two linear passes:
// first the indices >= PTR, then (only if nothing was found) from 0.
module rr_arbiter
#(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    REQ,
    input  logic [SELW-1:0] PTR,
    output logic [N-1:0]    GNT,
    output logic [SELW-1:0] GNT_IDX,
    output logic            ANY
);

    always_comb begin
        GNT     = '0;
        GNT_IDX = '0;
        ANY     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!ANY && REQ[i] && (int'(PTR) <= i)) begin
                ANY     = 1'b1;
                GNT[i]  = 1'b1;
                GNT_IDX = SELW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!ANY && REQ[i]) begin
                ANY     = 1'b1;
                GNT[i]  = 1'b1;
                GNT_IDX = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-to-1 multiplexer with a single registered output stage.
//   CLK     : clock, rising edge
//   RST_N   : synchronous active-low reset
//   bus     : mux_nto1_pipe_if.slave (channels, select, mode, result handshake)
//   SEL_ERR : sticky out-of-range select flag, present only when the macro
//             MUX_NTO1_SEL_ERR_EN is defined
// Direct mode takes channel C; round-robin mode grants the first valid channel
// at or above the rotating pointer. One transfer per cycle when the output
// is drained every cycle.
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT,
    parameter int N     = MUX_N_DEFAULT,
    parameter int SELW  = $clog2(N)
) (
    input  logic CLK,
    input  logic RST_N,
`ifdef MUX_NTO1_SEL_ERR_EN
    output logic SEL_ERR,
`endif
    mux_nto1_pipe_if.slave bus
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [SELW-1:0]  r_sel_q, r_sel_d;
    logic             r_valid_q, r_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;

    logic             free;
    logic             c_oob;
    logic [N-1:0]     x_ready;
    logic [SELW-1:0]  sel_idx;
    logic             acc;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .REQ     (bus.X_VALID),
        .PTR     (ptr_q),
        .GNT     (rr_gnt),
        .GNT_IDX (rr_idx),
        .ANY     (rr_any)
    );

    assign free = !r_valid_q || bus.R_READY;

    // C is out of range when it matches no channel index; avoids a constant
    // compare when N is a power of two.
    always_comb begin
        c_oob = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (bus.C == SELW'(i)) c_oob = 1'b0;
        end
    end

    // Direct-mode ready depends only on C, MODE and output state, never on X_VALID.
    always_comb begin
        x_ready = '0;
        sel_idx = '0;
        if (RST_N) begin
            if (bus.MODE == MUX_MODE_DIRECT) begin
                sel_idx = bus.C;
                for (int i = 0; i < N; i++) begin
                    x_ready[i] = free && (bus.C == SELW'(i));
                end
            end else begin
                sel_idx = rr_idx;
                x_ready = rr_gnt & {N{free}};
            end
        end
    end

    assign acc = |(x_ready & bus.X_VALID);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_idx == SELW'(i)) sel_data = bus.X[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        r_d       = r_q;
        r_sel_d   = r_sel_q;
        r_valid_d = r_valid_q;
        ptr_d     = ptr_q;
        if (acc) begin
            r_d       = sel_data;
            r_sel_d   = sel_idx;
            r_valid_d = 1'b1;
            if (bus.MODE == MUX_MODE_RR) begin
                ptr_d = (rr_idx == SELW'(N-1)) ? '0 : rr_idx + SELW'(1);
            end
        end else if (r_valid_q && bus.R_READY) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_q       <= '0;
            r_sel_q   <= '0;
            r_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            r_q       <= r_d;
            r_sel_q   <= r_sel_d;
            r_valid_q <= r_valid_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef MUX_NTO1_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    assign sel_err_d = sel_err_q || ((bus.MODE == MUX_MODE_DIRECT) && c_oob);

    always_ff @(posedge CLK) begin
        if (!RST_N) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign SEL_ERR = sel_err_q;
`else
    // Out-of-range C already yields no ready bit; nothing else to record.
    logic unused_c_oob;
    assign unused_c_oob = c_oob;
`endif

    assign bus.X_READY = x_ready;
    assign bus.R       = r_q;
    assign bus.R_SEL   = r_sel_q;
    assign bus.R_VALID = r_valid_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb_mux_nto1_pipe: directed bench for mux_nto1_pipe, one N=4 and one N=3 instance.
// Set MUX_NTO1_SEL_ERR_EN to also exercise the sticky select-error flag.
module tb_mux_nto1_pipe;

    logic CLK = 1'b0;
    logic RST_N;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    mux_nto1_pipe_if #(.WIDTH(32), .N(4)) bus ();
    mux_nto1_pipe_if #(.WIDTH(32), .N(3)) bus3 ();

`ifdef MUX_NTO1_SEL_ERR_EN
    logic sel_err4, sel_err3;
`endif

    mux_nto1_pipe #(.WIDTH(32), .N(4)) u_dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
`ifdef MUX_NTO1_SEL_ERR_EN
        .SEL_ERR (sel_err4),
`endif
        .bus     (bus.slave)
    );

    mux_nto1_pipe #(.WIDTH(32), .N(3)) u_dut3 (
        .CLK     (CLK),
        .RST_N   (RST_N),
`ifdef MUX_NTO1_SEL_ERR_EN
        .SEL_ERR (sel_err3),
`endif
        .bus     (bus3.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] rr_seq [8];
        rr_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};

        // reset, with channels valid so ready would otherwise be asserted
        RST_N        = 1'b0;
        bus.X        = '0;
        bus.X_VALID  = 4'b1111;
        bus.C        = 2'd0;
        bus.MODE     = 1'b0;
        bus.R_READY  = 1'b1;
        bus3.X       = {32'd3, 32'd2, 32'd1};
        bus3.X_VALID = 3'b000;
        bus3.C       = 2'd0;
        bus3.MODE    = 1'b0;
        bus3.R_READY = 1'b1;
        #1;
        check("rst_x_ready", 32'(bus.X_READY), 32'h0);
        tick();
        tick();
        check("rst_r", bus.R, 32'h0);
        check("rst_r_sel", 32'(bus.R_SEL), 32'h0);
        check("rst_r_valid", 32'(bus.R_VALID), 32'h0);
        check("rst3_r_valid", 32'(bus3.R_VALID), 32'h0);

        // direct select of channel 2
        RST_N  = 1'b1;
        bus.C  = 2'd2;
        bus.X  = {32'd4, 32'd3, 32'd2, 32'd1};
        #1;
        check("dir_x_ready", 32'(bus.X_READY), 32'h4);
        tick();
        check("dir_r", bus.R, 32'h3);
        check("dir_r_sel", 32'(bus.R_SEL), 32'h2);
        check("dir_r_valid", 32'(bus.R_VALID), 32'h1);

        // backpressure while channel 1 data changes
        bus.C = 2'd1;
        bus.X[63:32] = 32'd1;
        #1;
        check("bp_x_ready_free", 32'(bus.X_READY), 32'h2);
        tick();
        check("bp_load_r", bus.R, 32'h1);
        bus.R_READY = 1'b0;
        bus.X[63:32] = 32'd5;
        #1;
        check("bp_x_ready_stall", 32'(bus.X_READY), 32'h0);
        for (int k = 0; k < 3; k++) begin
            bus.MODE = k[0];
            bus.C    = 2'(k);
            tick();
            check("bp_hold_r", bus.R, 32'h1);
            check("bp_hold_r_sel", 32'(bus.R_SEL), 32'h1);
            check("bp_hold_r_valid", 32'(bus.R_VALID), 32'h1);
        end
        bus.MODE    = 1'b0;
        bus.C       = 2'd1;
        bus.R_READY = 1'b1;
        #1;
        check("bp_release_x_ready", 32'(bus.X_READY), 32'h2);
        tick();
        check("bp_new_r", bus.R, 32'h5);
        check("bp_new_r_valid", 32'(bus.R_VALID), 32'h1);
        bus.X_VALID = 4'b0000;
        tick();
        check("drain_r_valid", 32'(bus.R_VALID), 32'h0);
        check("drain_r_hold", bus.R, 32'h5);

        // round-robin over channels 0,1,3
        bus.MODE    = 1'b1;
        bus.X_VALID = 4'b1011;
        bus.X       = {32'd13, 32'd12, 32'd11, 32'd10};
        #1;
        check("rr_first_ready", 32'(bus.X_READY), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_r_sel", 32'(bus.R_SEL), 32'(rr_seq[k]));
            check("rr_r", bus.R, 32'd10 + 32'(rr_seq[k]));
        end
        check("rr_ptr2_ready", 32'(bus.X_READY), 32'h8);

        // mid-stream reset with pointer at 2
        RST_N       = 1'b0;
        bus.R_READY = 1'b0;
        #1;
        check("mrst_x_ready", 32'(bus.X_READY), 32'h0);
        tick();
        check("mrst_r", bus.R, 32'h0);
        check("mrst_r_sel", 32'(bus.R_SEL), 32'h0);
        check("mrst_r_valid", 32'(bus.R_VALID), 32'h0);
        RST_N       = 1'b1;
        bus.R_READY = 1'b1;
        #1;
        check("mrst_rr_ready", 32'(bus.X_READY), 32'h1);
        tick();
        check("mrst_rr_sel", 32'(bus.R_SEL), 32'h0);

        // a direct-mode accept must not move the pointer (now 1)
        bus.MODE = 1'b0;
        bus.C    = 2'd3;
        tick();
        check("mix_dir_sel", 32'(bus.R_SEL), 32'h3);
        check("mix_dir_r", bus.R, 32'd13);
        bus.MODE = 1'b1;
        #1;
        check("mix_rr_ready", 32'(bus.X_READY), 32'h2);
        tick();
        check("mix_rr_sel", 32'(bus.R_SEL), 32'h1);

        // full throughput on channel 0
        bus.MODE    = 1'b0;
        bus.C       = 2'd0;
        bus.X_VALID = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            bus.X[31:0] = 32'(k);
            tick();
            check("tput_r", bus.R, 32'(k));
            check("tput_r_valid", 32'(bus.R_VALID), 32'h1);
        end

        // N=3 with out-of-range select
`ifdef MUX_NTO1_SEL_ERR_EN
        check("n3_sel_err_clear", 32'(sel_err3), 32'h0);
`endif
        bus3.C       = 2'd3;
        bus3.X_VALID = 3'b111;
        #1;
        check("n3_oob_ready", 32'(bus3.X_READY), 32'h0);
        tick();
        check("n3_oob_r_valid", 32'(bus3.R_VALID), 32'h0);
`ifdef MUX_NTO1_SEL_ERR_EN
        check("n3_sel_err_set", 32'(sel_err3), 32'h1);
`endif
        bus3.C = 2'd0;
        #1;
        check("n3_c0_ready", 32'(bus3.X_READY), 32'h1);
        tick();
        check("n3_c0_r_valid", 32'(bus3.R_VALID), 32'h1);
        check("n3_c0_r", bus3.R, 32'h1);
        check("n3_c0_r_sel", 32'(bus3.R_SEL), 32'h0);
`ifdef MUX_NTO1_SEL_ERR_EN
        check("n3_sel_err_sticky", 32'(sel_err3), 32'h1);
        check("n4_sel_err_clear", 32'(sel_err4), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_nto1_pipe.md
MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width of each input channel and of R.
REQ-002 Parameter N, default 4, legal range 2..16: number of input channels.
REQ-003 Parameter SELW, default $clog2(N): select width.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  reset; synchronous, active-low.
REQ-006 X  input  N*WIDTH  flattened channel data; channel i occupies X[i*WIDTH +: WIDTH].
REQ-007 X_VALID  input  N  per-channel valid.
REQ-008 X_READY  output  N  per-channel ready; at most one bit set per cycle.
REQ-009 C  input  SELW  channel select, used in direct mode only.
REQ-010 MODE  input  1  0 = direct select by C, 1 = round-robin among valid channels.
REQ-011 R  output  WIDTH  registered selected data.
REQ-012 R_SEL  output  SELW  index of the channel that produced R.
REQ-013 R_VALID  output  1  R/R_SEL hold a transfer.
REQ-014 R_READY  input  1  downstream accepts R.

Function
REQ-015 Accept on channel i = X_VALID[i] & X_READY[i]; output transfer = R_VALID & R_READY.
REQ-016 Output register is free when R_VALID=0 or an output transfer occurs in the same cycle; X_READY is all-zero when not free.
REQ-017 Direct mode: X_READY[C] = free, all other bits 0; X_READY is combinational from C, MODE and output state only, never from X_VALID.
REQ-018 Direct mode, C >= N: X_READY all-zero; no accept.
REQ-019 Round-robin mode: grant = first channel with X_VALID set, searching from pointer PTR upward with wrap-around N-1 -> 0; X_READY[grant] = free.
REQ-020 PTR becomes (grant+1) mod N after a round-robin accept; unchanged otherwise, including all direct-mode cycles.
REQ-021 On accept: R <= selected channel data, R_SEL <= channel index, R_VALID <= 1, next edge; latency 1 cycle.
REQ-022 Output transfer without a same-cycle accept: R_VALID <= 0; R and R_SEL hold their values.
REQ-023 Output transfer with a same-cycle accept: R_VALID stays 1 and R/R_SEL load new data; throughput 1 transfer/cycle.
REQ-024 R_VALID=1 and R_READY=0: R, R_SEL, R_VALID stable; MODE or C changes have no effect on held data.
REQ-025 A MODE change takes effect in the same cycle; PTR is retained across mode changes.

Reset
REQ-026 RST_N=0 at a rising edge: R <= 0, R_SEL <= 0, R_VALID <= 0, PTR <= 0, and SEL_ERR <= 0 when present.
REQ-027 X_READY is all-zero while RST_N=0; a held transfer is discarded by reset.

Configuration
REQ-028 Macro MUX_NTO1_SEL_ERR_EN defined: output SEL_ERR (1 bit) exists; it sets the cycle after any cycle with MODE=0, C >= N and RST_N=1; it is sticky until reset.
REQ-029 Macro MUX_NTO1_SEL_ERR_EN undefined: SEL_ERR port and logic are absent; an out-of-range C is silently ignored per REQ-018.

Structure
REQ-030 Shared package mux_pkg holds MODE encoding constants (MUX_MODE_DIRECT=0, MUX_MODE_RR=1) and the default WIDTH/N constants.
REQ-031 Sub-module rr_arbiter (parameter N; inputs REQ[N], PTR; outputs GNT one-hot, GNT_IDX, ANY) implements REQ-019.

Verification (WIDTH=32, N=4 unless noted)
REQ-032 Direct: MODE=0, C=2, X_VALID=4'b1111, ch2=32'h0000_0003, R_READY=1 -> one cycle later R=3, R_SEL=2, R_VALID=1; X_READY=4'b0100.
REQ-033 Backpressure: R_VALID=1, R_READY=0 for 3 cycles while ch1 data changes 1->5 -> R holds; X_READY=0; after R_READY=1, one transfer, then the new accept follows.
REQ-034 Round-robin: MODE=1, X_VALID=4'b1011 constant, R_READY=1 -> R_SEL sequence 0,1,3,0,1,3.
REQ-035 Mid-stream reset: R_VALID=1, PTR=2, RST_N=0 for one edge -> R=0, R_VALID=0, PTR=0; next RR grant is the lowest valid channel.
REQ-036 N=3, MODE=0, C=3 -> X_READY=3'b000, no transfer; with MUX_NTO1_SEL_ERR_EN, SEL_ERR=1 next cycle and stays 1 after C=0.
REQ-037 Full throughput: MODE=0, C=0, X_VALID[0]=1 with incrementing data 1..8, R_READY=1 -> R=1..8 on 8 consecutive cycles, no bubbles.
